// File: rtl/cpu_pkg.sv
// ============================================================================
// Module : cpu_pkg
// Brief  : Opcodes, instruction field positions and fetch-state encoding
//          shared by the 24-bit CPU front end.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package cpu_pkg;

    localparam logic [3:0] OP_ADDI  = 4'b0001;
    localparam logic [3:0] OP_LS    = 4'b0010;
    localparam logic [3:0] OP_SS    = 4'b0011;
    localparam logic [3:0] OP_BEQ   = 4'b0100;
    localparam logic [3:0] OP_RTYPE = 4'b0110;
    localparam logic [3:0] OP_HALT  = 4'b1111;

    localparam int INSTR_WIDTH = 24;
    localparam int OPCODE_MSB  = 23;
    localparam int OPCODE_LSB  = 20;
    localparam int RS_MSB      = 19;
    localparam int RS_LSB      = 16;
    localparam int RT_MSB      = 15;
    localparam int RT_LSB      = 12;
    localparam int RD_MSB      = 11;
    localparam int RD_LSB      = 8;
    localparam int IMM_MSB     = 11;
    localparam int IMM_LSB     = 0;
    localparam int FUNCT_MSB   = 3;
    localparam int FUNCT_LSB   = 0;

    typedef enum logic [1:0] {
        ST_REQ     = 2'd0,
        ST_FULL    = 2'd1,
        ST_DISCARD = 2'd2,
        ST_HALTED  = 2'd3
    } fetch_state_e;

    function automatic logic [3:0] opcode_of(input logic [INSTR_WIDTH-1:0] word);
        return word[OPCODE_MSB:OPCODE_LSB];
    endfunction

endpackage

`default_nettype wire

// File: rtl/pc_reg.sv
// ============================================================================
// Module : pc_reg
// Brief  : Program counter with synchronous active-low reset, load and +1.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module pc_reg #(
    parameter int                     PC_WIDTH = 16,
    parameter logic [PC_WIDTH-1:0]    RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_load,
    input  logic [PC_WIDTH-1:0] i_target,
    input  logic                i_inc,
    output logic [PC_WIDTH-1:0] o_pc
);

    localparam logic [PC_WIDTH-1:0] C_ONE = {{(PC_WIDTH-1){1'b0}}, 1'b1};

    logic [PC_WIDTH-1:0] pc_d;
    logic [PC_WIDTH-1:0] pc_q;

    // A redirect wins over the sequential step.
    always_comb begin
        pc_d = pc_q;
        if (i_load) begin
            pc_d = i_target;
        end else if (i_inc) begin
            pc_d = pc_q + C_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign o_pc = pc_q;

endmodule

`default_nettype wire

// File: rtl/instr_fetch.sv
// ============================================================================
// Module : instr_fetch
// Brief  : Fetch stage: PC, ready/valid instruction-memory handshake,
//          instruction register, field split, branch redirect and halt.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module instr_fetch
    import cpu_pkg::*;
#(
    parameter int                  PC_WIDTH = 16,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0,
    parameter logic [3:0]          HALT_OP  = OP_HALT
) (
    input  logic                Clock,
    input  logic                Reset,
    output logic                IMemReq,
    output logic [PC_WIDTH-1:0] IMemAddr,
    input  logic                IMemReady,
    input  logic [23:0]         IMemData,
    input  logic                Stall,
    input  logic                BranchTaken,
    input  logic [PC_WIDTH-1:0] BranchTarget,
    output logic                InstrValid,
    output logic [23:0]         Instr,
    output logic [PC_WIDTH-1:0] PCOut,
    output logic [3:0]          OPCODE,
    output logic [3:0]          RS,
    output logic [3:0]          RT,
    output logic [3:0]          RD,
    output logic [11:0]         Imm,
    output logic [3:0]          Funct,
    output logic                Halted,
    output logic [15:0]         FetchCount
);

    fetch_state_e        state_d,  state_q;
    logic                req_d,    req_q;
    logic [PC_WIDTH-1:0] addr_d,   addr_q;
    logic                valid_d,  valid_q;
    logic [23:0]         ir_d,     ir_q;
    logic [PC_WIDTH-1:0] pcout_d,  pcout_q;
    logic                halted_d, halted_q;
    logic [15:0]         cnt_d,    cnt_q;

    logic [PC_WIDTH-1:0] w_pc;
    logic                w_pc_load;
    logic                w_pc_inc;
    logic                w_accept;
    logic                w_consume;

    pc_reg #(
        .PC_WIDTH (PC_WIDTH),
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk      (Clock),
        .rst_n    (Reset),
        .i_load   (w_pc_load),
        .i_target (BranchTarget),
        .i_inc    (w_pc_inc),
        .o_pc     (w_pc)
    );

    // Memory data counts only against a request that was actually on the bus.
    assign w_accept  = req_q && IMemReady;
    assign w_consume = valid_q && !Stall && !BranchTaken;

    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        addr_d    = addr_q;
        valid_d   = valid_q;
        ir_d      = ir_q;
        pcout_d   = pcout_q;
        halted_d  = halted_q;
        cnt_d     = cnt_q;
        w_pc_load = 1'b0;
        w_pc_inc  = 1'b0;

        unique case (state_q)
            ST_REQ: begin
                if (BranchTaken) begin
                    w_pc_load = 1'b1;
                    valid_d   = 1'b0;
                    if (req_q && !IMemReady) begin
                        // Request in flight: keep the old address until it returns.
                        state_d = ST_DISCARD;
                    end else begin
                        state_d = ST_REQ;
                        req_d   = 1'b1;
                        addr_d  = BranchTarget;
                    end
                end else if (w_accept) begin
                    ir_d     = IMemData;
                    pcout_d  = w_pc;
                    w_pc_inc = 1'b1;
                    valid_d  = 1'b1;
                    req_d    = 1'b0;
                    state_d  = ST_FULL;
                end else begin
                    req_d  = 1'b1;
                    addr_d = w_pc;
                end
            end

            ST_FULL: begin
                if (BranchTaken) begin
                    w_pc_load = 1'b1;
                    valid_d   = 1'b0;
                    req_d     = 1'b1;
                    addr_d    = BranchTarget;
                    state_d   = ST_REQ;
                end else if (w_consume) begin
                    valid_d = 1'b0;
                    cnt_d   = cnt_q + 16'd1;
                    if (opcode_of(ir_q) == HALT_OP) begin
                        halted_d = 1'b1;
                        req_d    = 1'b0;
                        state_d  = ST_HALTED;
                    end else begin
                        req_d   = 1'b1;
                        addr_d  = w_pc;
                        state_d = ST_REQ;
                    end
                end
            end

            ST_DISCARD: begin
                if (BranchTaken) begin
                    w_pc_load = 1'b1;
                    valid_d   = 1'b0;
                end else if (IMemReady) begin
                    req_d   = 1'b1;
                    addr_d  = w_pc;
                    state_d = ST_REQ;
                end
            end

            ST_HALTED: begin
                req_d    = 1'b0;
                valid_d  = 1'b0;
                halted_d = 1'b1;
            end

            default: begin
                state_d = ST_REQ;
                req_d   = 1'b0;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state_q  <= ST_REQ;
            req_q    <= 1'b0;
            addr_q   <= RESET_PC;
            valid_q  <= 1'b0;
            ir_q     <= '0;
            pcout_q  <= '0;
            halted_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            req_q    <= req_d;
            addr_q   <= addr_d;
            valid_q  <= valid_d;
            ir_q     <= ir_d;
            pcout_q  <= pcout_d;
            halted_q <= halted_d;
            cnt_q    <= cnt_d;
        end
    end

    assign IMemReq    = req_q;
    assign IMemAddr   = addr_q;
    assign InstrValid = valid_q;
    assign Instr      = ir_q;
    assign PCOut      = pcout_q;
    assign Halted     = halted_q;
    assign FetchCount = cnt_q;

    assign OPCODE = ir_q[OPCODE_MSB:OPCODE_LSB];
    assign RS     = ir_q[RS_MSB:RS_LSB];
    assign RT     = ir_q[RT_MSB:RT_LSB];
    assign RD     = ir_q[RD_MSB:RD_LSB];
    assign Imm    = ir_q[IMM_MSB:IMM_LSB];
    assign Funct  = ir_q[FUNCT_MSB:FUNCT_LSB];

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch.sv
// ============================================================================
// Module : tb_instr_fetch
// Brief  : Scenario-driven scoreboard bench for instr_fetch.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_instr_fetch;
    import cpu_pkg::*;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        IMemReq;
    logic [15:0] IMemAddr;
    logic        IMemReady;
    logic [23:0] IMemData;
    logic        Stall;
    logic        BranchTaken;
    logic [15:0] BranchTarget;
    logic        InstrValid;
    logic [23:0] Instr;
    logic [15:0] PCOut;
    logic [3:0]  OPCODE, RS, RT, RD, Funct;
    logic [11:0] Imm;
    logic        Halted;
    logic [15:0] FetchCount;

    int          errors = 0;
    int          checks = 0;
    logic [15:0] exp_cnt;

    typedef struct packed {
        logic [15:0] pc;
        logic [23:0] instr;
    } exp_t;

    exp_t sb[$];
    exp_t e;

    always #5 Clock = ~Clock;

    instr_fetch #(.PC_WIDTH(16), .RESET_PC(16'h0000), .HALT_OP(4'b1111)) dut (
        .Clock(Clock), .Reset(Reset), .IMemReq(IMemReq), .IMemAddr(IMemAddr),
        .IMemReady(IMemReady), .IMemData(IMemData), .Stall(Stall),
        .BranchTaken(BranchTaken), .BranchTarget(BranchTarget),
        .InstrValid(InstrValid), .Instr(Instr), .PCOut(PCOut), .OPCODE(OPCODE),
        .RS(RS), .RT(RT), .RD(RD), .Imm(Imm), .Funct(Funct), .Halted(Halted),
        .FetchCount(FetchCount)
    );

    function automatic logic [23:0] mem_word(input logic [15:0] a);
        return {16'h6123, a[7:0]};
    endfunction

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic push_exp(input logic [15:0] pc, input logic [23:0] w);
        exp_t x;
        x.pc    = pc;
        x.instr = w;
        sb.push_back(x);
    endtask

    task automatic test_reset();
        Reset = 1'b0; IMemReady = 1'b0; IMemData = '0; Stall = 1'b0;
        BranchTaken = 1'b0; BranchTarget = '0; exp_cnt = '0;
        tick(); tick();
        checks++;
        if (IMemReq !== 1'b0 || InstrValid !== 1'b0 || Instr !== 24'h0 || PCOut !== 16'h0 ||
            Halted !== 1'b0 || FetchCount !== 16'h0 || OPCODE !== 4'h0 || Imm !== 12'h0) begin
            errors++;
            $display("FAIL reset_state: got req=%b valid=%b instr=%h pcout=%h halted=%b cnt=%h expected all zero",
                     IMemReq, InstrValid, Instr, PCOut, Halted, FetchCount);
        end
        Reset = 1'b1;
        #1;
        checks++;
        if (IMemReq !== 1'b0) begin
            errors++;
            $display("FAIL req_after_release: got %b expected 0", IMemReq);
        end
        tick();
        checks++;
        if (IMemReq !== 1'b1 || IMemAddr !== 16'h0000) begin
            errors++;
            $display("FAIL first_req: got req=%b addr=%h expected req=1 addr=0000", IMemReq, IMemAddr);
        end
    endtask

    task automatic test_stream();
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (IMemAddr !== 16'(k) || IMemReq !== 1'b1) begin
                errors++;
                $display("FAIL stream_addr: got req=%b addr=%h expected req=1 addr=%h", IMemReq, IMemAddr, 16'(k));
            end
            IMemData = mem_word(IMemAddr); IMemReady = 1'b1;
            push_exp(16'(k), mem_word(16'(k)));
            tick();
            IMemReady = 1'b0;
            e = sb.pop_front();
            checks++;
            if (InstrValid !== 1'b1 || Instr !== e.instr || PCOut !== e.pc) begin
                errors++;
                $display("FAIL stream_ir: got valid=%b instr=%h pc=%h expected valid=1 instr=%h pc=%h",
                         InstrValid, Instr, PCOut, e.instr, e.pc);
            end
            checks++;
            if ({OPCODE, RS, RT, RD} !== 16'h6123 || IMemReq !== 1'b0) begin
                errors++;
                $display("FAIL stream_fields: got op/rs/rt/rd=%h req=%b expected 6123 req=0",
                         {OPCODE, RS, RT, RD}, IMemReq);
            end
            tick();
            exp_cnt++;
            checks++;
            if (InstrValid !== 1'b0 || IMemReq !== 1'b1) begin
                errors++;
                $display("FAIL stream_consume: got valid=%b req=%b expected valid=0 req=1", InstrValid, IMemReq);
            end
        end
        checks++;
        if (FetchCount !== exp_cnt) begin
            errors++;
            $display("FAIL stream_count: got %h expected %h", FetchCount, exp_cnt);
        end
    endtask

    task automatic test_stall();
        IMemData = mem_word(IMemAddr); IMemReady = 1'b1;
        push_exp(16'h0004, mem_word(16'h0004));
        tick();
        IMemReady = 1'b0; Stall = 1'b1;
        e = sb.pop_front();
        for (int c = 0; c < 5; c++) begin
            tick();
            checks++;
            if (InstrValid !== 1'b1 || Instr !== e.instr || PCOut !== e.pc || IMemReq !== 1'b0 ||
                FetchCount !== exp_cnt) begin
                errors++;
                $display("FAIL stall_hold: got valid=%b instr=%h pc=%h req=%b cnt=%h expected 1 %h %h 0 %h",
                         InstrValid, Instr, PCOut, IMemReq, FetchCount, e.instr, e.pc, exp_cnt);
            end
        end
        Stall = 1'b0;
        tick();
        exp_cnt++;
        checks++;
        if (FetchCount !== exp_cnt || IMemReq !== 1'b1 || IMemAddr !== 16'h0005) begin
            errors++;
            $display("FAIL stall_release: got cnt=%h req=%b addr=%h expected cnt=%h req=1 addr=0005",
                     FetchCount, IMemReq, IMemAddr, exp_cnt);
        end
    endtask

    task automatic test_branch_wait();
        for (int c = 0; c < 4; c++) begin
            if (c == 1) begin
                BranchTaken = 1'b1; BranchTarget = 16'h0040;
            end
            if (c == 3) begin
                IMemReady = 1'b1; IMemData = mem_word(IMemAddr);
            end
            tick();
            BranchTaken = 1'b0;
            if (c < 3) begin
                checks++;
                if (IMemAddr !== 16'h0005 || IMemReq !== 1'b1 || InstrValid !== 1'b0) begin
                    errors++;
                    $display("FAIL wait_hold: got addr=%h req=%b valid=%b expected 0005 1 0",
                             IMemAddr, IMemReq, InstrValid);
                end
            end
        end
        IMemReady = 1'b0;
        checks++;
        if (InstrValid !== 1'b0 || IMemReq !== 1'b1 || IMemAddr !== 16'h0040) begin
            errors++;
            $display("FAIL wait_redirect: got valid=%b req=%b addr=%h expected 0 1 0040",
                     InstrValid, IMemReq, IMemAddr);
        end
        IMemReady = 1'b1; IMemData = mem_word(IMemAddr);
        push_exp(16'h0040, mem_word(16'h0040));
        tick();
        IMemReady = 1'b0;
        e = sb.pop_front();
        checks++;
        if (InstrValid !== 1'b1 || Instr !== e.instr || PCOut !== e.pc) begin
            errors++;
            $display("FAIL target_fetch: got valid=%b instr=%h pc=%h expected 1 %h %h",
                     InstrValid, Instr, PCOut, e.instr, e.pc);
        end
        tick();
        exp_cnt++;
    endtask

    task automatic test_branch_same_cycle();
        IMemReady = 1'b1; IMemData = mem_word(IMemAddr);
        BranchTaken = 1'b1; BranchTarget = 16'h0080;
        tick();
        IMemReady = 1'b0; BranchTaken = 1'b0;
        checks++;
        if (InstrValid !== 1'b0 || IMemReq !== 1'b1 || IMemAddr !== 16'h0080 || FetchCount !== exp_cnt) begin
            errors++;
            $display("FAIL same_cycle: got valid=%b req=%b addr=%h cnt=%h expected 0 1 0080 %h",
                     InstrValid, IMemReq, IMemAddr, FetchCount, exp_cnt);
        end
        IMemReady = 1'b1; IMemData = mem_word(IMemAddr);
        push_exp(16'h0080, mem_word(16'h0080));
        tick();
        IMemReady = 1'b0;
        e = sb.pop_front();
        checks++;
        if (InstrValid !== 1'b1 || Instr !== e.instr || PCOut !== e.pc) begin
            errors++;
            $display("FAIL full_fetch: got valid=%b instr=%h pc=%h expected 1 %h %h",
                     InstrValid, Instr, PCOut, e.instr, e.pc);
        end
        // Redirect from FULL must override an active stall.
        Stall = 1'b1; BranchTaken = 1'b1; BranchTarget = 16'hFFFF;
        tick();
        Stall = 1'b0; BranchTaken = 1'b0;
        checks++;
        if (InstrValid !== 1'b0 || IMemReq !== 1'b1 || IMemAddr !== 16'hFFFF || FetchCount !== exp_cnt) begin
            errors++;
            $display("FAIL full_redirect: got valid=%b req=%b addr=%h cnt=%h expected 0 1 ffff %h",
                     InstrValid, IMemReq, IMemAddr, FetchCount, exp_cnt);
        end
    endtask

    task automatic test_wrap();
        IMemReady = 1'b1; IMemData = mem_word(IMemAddr);
        push_exp(16'hFFFF, mem_word(16'hFFFF));
        tick();
        IMemReady = 1'b0;
        e = sb.pop_front();
        checks++;
        if (InstrValid !== 1'b1 || Instr !== e.instr || PCOut !== e.pc) begin
            errors++;
            $display("FAIL wrap_fetch: got valid=%b instr=%h pc=%h expected 1 %h %h",
                     InstrValid, Instr, PCOut, e.instr, e.pc);
        end
        tick();
        exp_cnt++;
        checks++;
        if (IMemReq !== 1'b1 || IMemAddr !== 16'h0000 || FetchCount !== exp_cnt) begin
            errors++;
            $display("FAIL wrap_addr: got req=%b addr=%h cnt=%h expected 1 0000 %h",
                     IMemReq, IMemAddr, FetchCount, exp_cnt);
        end
    endtask

    task automatic test_halt();
        IMemReady = 1'b1; IMemData = 24'hF00000;
        push_exp(16'h0000, 24'hF00000);
        tick();
        IMemReady = 1'b0;
        e = sb.pop_front();
        checks++;
        if (InstrValid !== 1'b1 || Instr !== e.instr || PCOut !== e.pc || OPCODE !== OP_HALT) begin
            errors++;
            $display("FAIL halt_fetch: got valid=%b instr=%h pc=%h op=%h expected 1 %h %h f",
                     InstrValid, Instr, PCOut, OPCODE, e.instr, e.pc);
        end
        tick();
        exp_cnt++;
        for (int c = 0; c < 4; c++) begin
            BranchTaken = (c == 1); BranchTarget = 16'h0123;
            tick();
            checks++;
            if (Halted !== 1'b1 || IMemReq !== 1'b0 || InstrValid !== 1'b0 || FetchCount !== exp_cnt) begin
                errors++;
                $display("FAIL halted_state: got halted=%b req=%b valid=%b cnt=%h expected 1 0 0 %h",
                         Halted, IMemReq, InstrValid, FetchCount, exp_cnt);
            end
        end
        BranchTaken = 1'b0;
        Reset = 1'b0;
        tick();
        Reset = 1'b1;
        exp_cnt = '0;
        tick();
        checks++;
        if (Halted !== 1'b0 || FetchCount !== 16'h0 || IMemReq !== 1'b1 || IMemAddr !== 16'h0000) begin
            errors++;
            $display("FAIL halt_restart: got halted=%b cnt=%h req=%b addr=%h expected 0 0000 1 0000",
                     Halted, FetchCount, IMemReq, IMemAddr);
        end
    endtask

    task automatic test_reset_midwait();
        IMemReady = 1'b1; IMemData = mem_word(IMemAddr);
        push_exp(16'h0000, mem_word(16'h0000));
        tick();
        IMemReady = 1'b0;
        e = sb.pop_front();
        checks++;
        if (InstrValid !== 1'b1 || Instr !== e.instr || PCOut !== e.pc) begin
            errors++;
            $display("FAIL pre_reset_fetch: got valid=%b instr=%h pc=%h expected 1 %h %h",
                     InstrValid, Instr, PCOut, e.instr, e.pc);
        end
        tick(); tick(); tick();
        checks++;
        if (IMemReq !== 1'b1 || IMemAddr !== 16'h0001 || FetchCount !== 16'h0001) begin
            errors++;
            $display("FAIL midwait_pending: got req=%b addr=%h cnt=%h expected 1 0001 0001",
                     IMemReq, IMemAddr, FetchCount);
        end
        Reset = 1'b0;
        tick();
        checks++;
        if (IMemReq !== 1'b0 || InstrValid !== 1'b0 || Instr !== 24'h0 || PCOut !== 16'h0 ||
            Halted !== 1'b0 || FetchCount !== 16'h0 || RS !== 4'h0) begin
            errors++;
            $display("FAIL midwait_reset: got req=%b valid=%b instr=%h pc=%h halted=%b cnt=%h expected all zero",
                     IMemReq, InstrValid, Instr, PCOut, Halted, FetchCount);
        end
        Reset = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_branch_wait();
        test_branch_same_cycle();
        test_wrap();
        test_halt();
        test_reset_midwait();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
